// File: rtl/vga_axi_rd_arbiter_pkg.sv
// Shared types and constants for the VGA AXI read arbiter.
// Used by vga_axi_rd_arbiter and vga_axi_rd_arbiter_sel.
package vga_axi_rd_arbiter_pkg;

   // The FSM runs IDLE -> ADDR -> DATA -> IDLE.
   // DRAIN swallows the overrun beats of a burst that the slave ended too late.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ADDR  = 2'd1,
      ST_DATA  = 2'd2,
      ST_DRAIN = 2'd3
   } arb_state_e;

   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
   localparam logic [7:0] ERR_CNT_MAX    = 8'hFF;

   // Adds 0..2 to the error counter and clamps the result at ERR_CNT_MAX.
   function automatic logic [7:0] err_sat_add(input logic [7:0] cnt, input logic [1:0] inc);
      logic [8:0] sum;
      sum = {1'b0, cnt} + {7'd0, inc};
      return sum[8] ? ERR_CNT_MAX : sum[7:0];
   endfunction

endpackage

// File: rtl/vga_axi_rd_arbiter_sel.sv
// Two-way grant selector for the VGA read arbiter.
// Macro VGA_ARB_RR_EN: when defined, a tie goes to the client that did not win last time.
// When it is undefined, client 0 has fixed priority.
// The pointer remembers the last winner and drives grant_o of the top level.
module vga_axi_rd_arbiter_sel
   import vga_axi_rd_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req_i,
   input  logic       upd_i,
   output logic       gnt_vld_o,
   output logic       gnt_idx_o,
   output logic       last_o
);

   logic last_q, last_d;
`ifdef VGA_ARB_RR_EN
   logic seen_q, seen_d;
`endif

   // Choose the winner among the current requests.
   always_comb begin
      gnt_vld_o = |req_i;
      gnt_idx_o = 1'b0;
      if (req_i == 2'b11) begin
`ifdef VGA_ARB_RR_EN
         // Until anyone has been granted, client 0 wins a tie.
         gnt_idx_o = seen_q ? ~last_q : 1'b0;
`else
         gnt_idx_o = 1'b0;
`endif
      end else if (req_i[1]) begin
         gnt_idx_o = 1'b1;
      end else begin
         gnt_idx_o = 1'b0;
      end
   end

   // Next value of the last-winner pointer.
   always_comb begin
      last_d = last_q;
`ifdef VGA_ARB_RR_EN
      seen_d = seen_q;
`endif
      if (upd_i) begin
         last_d = gnt_idx_o;
`ifdef VGA_ARB_RR_EN
         seen_d = 1'b1;
`endif
      end else begin
         last_d = last_q;
      end
   end

   // Last-winner pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b0;
`ifdef VGA_ARB_RR_EN
         seen_q <= 1'b0;
`endif
      end else begin
         last_q <= last_d;
`ifdef VGA_ARB_RR_EN
         seen_q <= seen_d;
`endif
      end
   end

   assign last_o = last_q;

endmodule

// File: rtl/vga_axi_rd_arbiter.sv
// AXI4 read-channel arbiter shared by two VGA fetch clients.
// Client 0 is the line fetch and client 1 is the cursor/overlay fetch.
// Only one burst is in flight at a time.
// Each burst is length-checked, and length and response errors are counted.
// Macro VGA_ARB_RR_EN: when defined, ties are arbitrated round-robin; otherwise client 0 wins.
module vga_axi_rd_arbiter
   import vga_axi_rd_arbiter_pkg::*;
#(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
)
(
   input  logic                  clk_a,
   input  logic                  resetn_a,
   input  logic [ADDR_WIDTH-1:0] s0_araddr_i,
   input  logic [7:0]            s0_arlen_i,
   input  logic                  s0_arvalid_i,
   output logic                  s0_arready_o,
   input  logic [ADDR_WIDTH-1:0] s1_araddr_i,
   input  logic [7:0]            s1_arlen_i,
   input  logic                  s1_arvalid_i,
   output logic                  s1_arready_o,
   output logic [DATA_WIDTH-1:0] rdata_o,
   output logic [1:0]            rresp_o,
   output logic                  rlast_o,
   output logic                  s0_rvalid_o,
   input  logic                  s0_rready_i,
   output logic                  s1_rvalid_o,
   input  logic                  s1_rready_i,
   output logic [ADDR_WIDTH-1:0] araddr_o,
   output logic [7:0]            arlen_o,
   output logic [2:0]            arsize_o,
   output logic [1:0]            arburst_o,
   output logic                  arvalid_o,
   input  logic                  arready_i,
   input  logic [DATA_WIDTH-1:0] rdata_i,
   input  logic [1:0]            rresp_i,
   input  logic                  rlast_i,
   input  logic                  rvalid_i,
   output logic                  rready_o,
   output logic                  grant_o,
   output logic [7:0]            err_cnt_o,
   input  logic                  err_clr_i
);

   localparam logic [2:0] AR_SIZE = 3'($clog2(DATA_WIDTH / 8));

   arb_state_e            state_q, state_d;
   logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
   logic [7:0]            arlen_q, arlen_d;
   logic                  arvalid_q, arvalid_d;
   logic                  s0_arready_q, s0_arready_d;
   logic                  s1_arready_q, s1_arready_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [7:0]            err_q, err_d;

   logic       gnt_vld_s, gnt_idx_s, grant_s, sel_upd_s;
   logic       in_data_s, cnt_zero_s, r_hs_s, len_err_s, resp_err_s;
   logic [1:0] err_inc_s;

   vga_axi_rd_arbiter_sel u_sel (
      .clk       (clk_a),
      .rst_n     (resetn_a),
      .req_i     ({s1_arvalid_i, s0_arvalid_i}),
      .upd_i     (sel_upd_s),
      .gnt_vld_o (gnt_vld_s),
      .gnt_idx_o (gnt_idx_s),
      .last_o    (grant_s)
   );

   // R channel: a pass-through gated by the grant, plus the burst-end and error detection.
   always_comb begin
      in_data_s   = (state_q == ST_DATA);
      cnt_zero_s  = (cnt_q == 8'd0);
      rdata_o     = rdata_i;
      rresp_o     = rresp_i;
      rlast_o     = in_data_s & (rlast_i | cnt_zero_s);
      s0_rvalid_o = in_data_s & rvalid_i & ~grant_s;
      s1_rvalid_o = in_data_s & rvalid_i & grant_s;
      if (in_data_s) begin
         rready_o = grant_s ? s1_rready_i : s0_rready_i;
      end else if (state_q == ST_DRAIN) begin
         rready_o = 1'b1;
      end else begin
         rready_o = 1'b0;
      end
      r_hs_s     = in_data_s & rvalid_i & rready_o;
      len_err_s  = r_hs_s & (rlast_i ^ cnt_zero_s);
      resp_err_s = r_hs_s & (rresp_i != AXI_RESP_OKAY);
      err_inc_s  = {1'b0, len_err_s} + {1'b0, resp_err_s};
   end

   // Next-state logic: the FSM sequencing, the latched AR payload and the error counter.
   always_comb begin
      state_d      = state_q;
      araddr_d     = araddr_q;
      arlen_d      = arlen_q;
      arvalid_d    = arvalid_q;
      cnt_d        = cnt_q;
      s0_arready_d = 1'b0;
      s1_arready_d = 1'b0;
      sel_upd_s    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (gnt_vld_s) begin
               sel_upd_s = 1'b1;
               state_d   = ST_ADDR;
               arvalid_d = 1'b1;
               if (gnt_idx_s) begin
                  araddr_d     = s1_araddr_i;
                  arlen_d      = s1_arlen_i;
                  cnt_d        = s1_arlen_i;
                  s1_arready_d = 1'b1;
               end else begin
                  araddr_d     = s0_araddr_i;
                  arlen_d      = s0_arlen_i;
                  cnt_d        = s0_arlen_i;
                  s0_arready_d = 1'b1;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR: begin
            if (arready_i) begin
               arvalid_d = 1'b0;
               state_d   = ST_DATA;
            end else begin
               state_d = ST_ADDR;
            end
         end
         ST_DATA: begin
            if (r_hs_s && (rlast_i || cnt_zero_s)) begin
               // If the slave has not yet sent rlast, its remaining beats are drained.
               state_d = rlast_i ? ST_IDLE : ST_DRAIN;
            end else if (r_hs_s) begin
               cnt_d = cnt_q - 8'd1;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_DRAIN: begin
            if (rvalid_i && rlast_i) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            arvalid_d = 1'b0;
         end
      endcase
      if (err_clr_i) begin
         err_d = 8'd0;
      end else begin
         err_d = err_sat_add(err_q, err_inc_s);
      end
   end

   // State and registered AR outputs; reset aborts any burst in flight.
   always_ff @(posedge clk_a or negedge resetn_a) begin
      if (!resetn_a) begin
         state_q      <= ST_IDLE;
         araddr_q     <= '0;
         arlen_q      <= 8'd0;
         arvalid_q    <= 1'b0;
         s0_arready_q <= 1'b0;
         s1_arready_q <= 1'b0;
         cnt_q        <= 8'd0;
         err_q        <= 8'd0;
      end else begin
         state_q      <= state_d;
         araddr_q     <= araddr_d;
         arlen_q      <= arlen_d;
         arvalid_q    <= arvalid_d;
         s0_arready_q <= s0_arready_d;
         s1_arready_q <= s1_arready_d;
         cnt_q        <= cnt_d;
         err_q        <= err_d;
      end
   end

   assign araddr_o     = araddr_q;
   assign arlen_o      = arlen_q;
   assign arvalid_o    = arvalid_q;
   assign arsize_o     = AR_SIZE;
   assign arburst_o    = AXI_BURST_INCR;
   assign s0_arready_o = s0_arready_q;
   assign s1_arready_o = s1_arready_q;
   assign grant_o      = grant_s;
   assign err_cnt_o    = err_q;

endmodule

// File: tb/tb_vga_axi_rd_arbiter.sv
// Directed testbench for vga_axi_rd_arbiter.
// It covers arbitration, burst forwarding, length and response errors, error saturation and mid-burst reset.
module tb_vga_axi_rd_arbiter;

   logic        clk_a = 1'b0;
   logic        resetn_a;
   logic [63:0] s0_araddr_i, s1_araddr_i;
   logic [7:0]  s0_arlen_i, s1_arlen_i;
   logic        s0_arvalid_i, s1_arvalid_i, s0_arready_o, s1_arready_o;
   logic [63:0] rdata_o;
   logic [1:0]  rresp_o;
   logic        rlast_o, s0_rvalid_o, s1_rvalid_o, s0_rready_i, s1_rready_i;
   logic [63:0] araddr_o;
   logic [7:0]  arlen_o;
   logic [2:0]  arsize_o;
   logic [1:0]  arburst_o;
   logic        arvalid_o, arready_i;
   logic [63:0] rdata_i;
   logic [1:0]  rresp_i;
   logic        rlast_i, rvalid_i, rready_o, grant_o;
   logic [7:0]  err_cnt_o;
   logic        err_clr_i;

   int passed = 0;
   int total  = 0;
   int won;
   int exp_tie;

   vga_axi_rd_arbiter #(.ADDR_WIDTH(64), .DATA_WIDTH(64)) dut (
      .clk_a(clk_a), .resetn_a(resetn_a),
      .s0_araddr_i(s0_araddr_i), .s0_arlen_i(s0_arlen_i), .s0_arvalid_i(s0_arvalid_i), .s0_arready_o(s0_arready_o),
      .s1_araddr_i(s1_araddr_i), .s1_arlen_i(s1_arlen_i), .s1_arvalid_i(s1_arvalid_i), .s1_arready_o(s1_arready_o),
      .rdata_o(rdata_o), .rresp_o(rresp_o), .rlast_o(rlast_o),
      .s0_rvalid_o(s0_rvalid_o), .s0_rready_i(s0_rready_i),
      .s1_rvalid_o(s1_rvalid_o), .s1_rready_i(s1_rready_i),
      .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o), .arburst_o(arburst_o),
      .arvalid_o(arvalid_o), .arready_i(arready_i),
      .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
      .grant_o(grant_o), .err_cnt_o(err_cnt_o), .err_clr_i(err_clr_i)
   );

   // 100 MHz clock.
   always #5 clk_a = ~clk_a;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
   endtask

   // Raises the requested arvalids and waits for the accept pulse.
   // It then drops the winner's request. It returns at posedge+1.
   task automatic request(input logic r0, input logic r1, output int w);
      int  n;
      logic got;
      n = 0;
      got = 1'b0;
      if (r0) s0_arvalid_i = 1'b1;
      if (r1) s1_arvalid_i = 1'b1;
      while (!got && n < 8) begin
         @(negedge clk_a);
         if (s0_arready_o || s1_arready_o) got = 1'b1;
         else begin
            @(posedge clk_a); #1;
            n++;
         end
      end
      chk("ar_accept_seen", got, 1'b1);
      chk("ar_onehot", s0_arready_o & s1_arready_o, 1'b0);
      chk("arvalid_with_accept", arvalid_o, 1'b1);
      w = s1_arready_o ? 1 : 0;
      @(posedge clk_a); #1;
      if (w == 1) s1_arvalid_i = 1'b0;
      else s0_arvalid_i = 1'b0;
   endtask

   // Holds arready low for 'waits' cycles, then performs the AR handshake.
   task automatic addr_phase(input int waits);
      arready_i = 1'b0;
      for (int i = 0; i < waits; i++) begin
         @(negedge clk_a);
         chk("arvalid_hold", arvalid_o, 1'b1);
         @(posedge clk_a); #1;
      end
      arready_i = 1'b1;
      @(posedge clk_a); #1;
      arready_i = 1'b0;
      #1;
      chk("arvalid_drop", arvalid_o, 1'b0);
   endtask

   // The slave sends nbeats beats and raises rlast on beat last_at.
   // Beats 1..nerr carry SLVERR, and err_clr is pulsed on beat clr_beat.
   // Beats beyond exp_fwd are expected to be drained rather than forwarded.
   task automatic data_phase(input int cli, input int nbeats, input int last_at,
                             input int nerr, input int clr_beat, input int exp_fwd);
      logic [63:0] d;
      s0_rready_i = (cli == 0);
      s1_rready_i = (cli == 1);
      for (int k = 1; k <= nbeats; k++) begin
         d         = 64'hA5A5_0000_0000_0000 + 64'(k);
         rvalid_i  = 1'b1;
         rdata_i   = d;
         rlast_i   = (k == last_at);
         rresp_i   = (k <= nerr) ? 2'b10 : 2'b00;
         err_clr_i = (k == clr_beat);
         @(negedge clk_a);
         if (k <= exp_fwd) begin
            chk("rvalid_granted", (cli == 1) ? s1_rvalid_o : s0_rvalid_o, 1'b1);
            chk("rvalid_other", (cli == 1) ? s0_rvalid_o : s1_rvalid_o, 1'b0);
            chk("rlast_o", rlast_o, (k == exp_fwd));
            chk("rdata_o", rdata_o, d);
            chk("rready_o", rready_o, 1'b1);
         end else begin
            chk("drain_no_fwd", s0_rvalid_o | s1_rvalid_o, 1'b0);
            chk("drain_rready", rready_o, 1'b1);
         end
         @(posedge clk_a); #1;
      end
      rvalid_i = 1'b0; rlast_i = 1'b0; rresp_i = 2'b00; err_clr_i = 1'b0;
      s0_rready_i = 1'b0; s1_rready_i = 1'b0;
      #1;
      chk("idle_rready", rready_o, 1'b0);
   endtask

   initial begin
      resetn_a = 1'b0;
      s0_araddr_i = 64'd0; s1_araddr_i = 64'd0; s0_arlen_i = 8'd0; s1_arlen_i = 8'd0;
      s0_arvalid_i = 1'b0; s1_arvalid_i = 1'b0; s0_rready_i = 1'b0; s1_rready_i = 1'b0;
      arready_i = 1'b0; rdata_i = 64'd0; rresp_i = 2'b00; rlast_i = 1'b0; rvalid_i = 1'b0;
      err_clr_i = 1'b0;
      #3;
      chk("rst_arvalid", arvalid_o, 1'b0);
      chk("rst_araddr", araddr_o, 64'd0);
      chk("rst_arlen", arlen_o, 8'd0);
      chk("rst_err", err_cnt_o, 8'd0);
      chk("rst_grant", grant_o, 1'b0);
      chk("rst_arready", s0_arready_o | s1_arready_o, 1'b0);
      chk("rst_rready", rready_o, 1'b0);
      chk("rst_rlast", rlast_o, 1'b0);
      chk("arsize", arsize_o, 3'd3);
      chk("arburst", arburst_o, 2'b01);
      @(posedge clk_a); #1;
      @(posedge clk_a); #1;
      resetn_a = 1'b1;
      @(posedge clk_a); #1;

      // Client 0 alone: addr 0x1000, len 7, arready after 2 cycles, 8 beats.
      s0_araddr_i = 64'h1000; s0_arlen_i = 8'd7;
      request(1'b1, 1'b0, won);
      chk("A_winner", won, 0);
      chk("A_araddr", araddr_o, 64'h1000);
      chk("A_arlen", arlen_o, 8'd7);
      addr_phase(2);
      data_phase(0, 8, 8, 0, 0, 8);
      chk("A_err", err_cnt_o, 8'd0);

      // A tie goes to client 0. The second tie depends on the arbitration mode.
      s0_araddr_i = 64'h4000; s0_arlen_i = 8'd0;
      s1_araddr_i = 64'h5000; s1_arlen_i = 8'd0;
      request(1'b1, 1'b1, won);
      chk("B_tie1_winner", won, 0);
      chk("B_araddr", araddr_o, 64'h4000);
      addr_phase(0);
      data_phase(0, 1, 1, 0, 0, 1);
      s0_arvalid_i = 1'b1;
`ifdef VGA_ARB_RR_EN
      exp_tie = 1;
`else
      exp_tie = 0;
`endif
      request(1'b1, 1'b1, won);
      chk("B_tie2_winner", won, exp_tie);
      chk("B_tie2_grant", grant_o, 1'(exp_tie));
      chk("B_tie2_araddr", araddr_o, (exp_tie == 1) ? 64'h5000 : 64'h4000);
      addr_phase(0);
      data_phase(exp_tie, 1, 1, 0, 0, 1);
      request(exp_tie == 1, exp_tie == 0, won);
      chk("B_last_winner", won, 1 - exp_tie);
      chk("B_last_araddr", araddr_o, (exp_tie == 1) ? 64'h4000 : 64'h5000);
      addr_phase(1);
      data_phase(1 - exp_tie, 1, 1, 0, 0, 1);
      chk("B_err", err_cnt_o, 8'd0);

      // Length errors: an early rlast on beat 2, then a missing rlast on beat 4.
      s0_araddr_i = 64'h6000; s0_arlen_i = 8'd3;
      request(1'b1, 1'b0, won);
      addr_phase(0);
      data_phase(0, 2, 2, 0, 0, 2);
      chk("C_early_err", err_cnt_o, 8'd1);
      request(1'b1, 1'b0, won);
      addr_phase(0);
      data_phase(0, 5, 5, 0, 0, 4);
      chk("C_late_err", err_cnt_o, 8'd2);

      // Response errors, clear priority and saturation.
      err_clr_i = 1'b1;
      @(posedge clk_a); #1;
      err_clr_i = 1'b0;
      #1;
      chk("D_clr", err_cnt_o, 8'd0);
      request(1'b1, 1'b0, won);
      addr_phase(0);
      data_phase(0, 4, 4, 3, 0, 4);
      chk("D_resp3", err_cnt_o, 8'd3);
      s0_arlen_i = 8'd0;
      request(1'b1, 1'b0, won);
      addr_phase(0);
      data_phase(0, 1, 1, 1, 1, 1);
      chk("D_clr_wins", err_cnt_o, 8'd0);
      s0_arlen_i = 8'd255;
      request(1'b1, 1'b0, won);
      chk("D_arlen255", arlen_o, 8'd255);
      addr_phase(0);
      data_phase(0, 256, 256, 256, 0, 256);
      chk("D_sat256", err_cnt_o, 8'hFF);
      s0_arlen_i = 8'd43;
      request(1'b1, 1'b0, won);
      addr_phase(0);
      data_phase(0, 44, 44, 44, 0, 44);
      chk("D_sat300", err_cnt_o, 8'hFF);

      // Reset during beat 2 of a client 1 burst, then a fresh client 0 burst.
      s1_araddr_i = 64'h7000; s1_arlen_i = 8'd3;
      request(1'b0, 1'b1, won);
      chk("E_winner", won, 1);
      addr_phase(0);
      s1_rready_i = 1'b1; rvalid_i = 1'b1; rdata_i = 64'h11;
      @(negedge clk_a);
      chk("E_beat1", s1_rvalid_o, 1'b1);
      @(posedge clk_a); #1;
      rdata_i = 64'h22;
      resetn_a = 1'b0;
      #1;
      chk("E_rst_rvalid", s0_rvalid_o | s1_rvalid_o, 1'b0);
      chk("E_rst_rready", rready_o, 1'b0);
      chk("E_rst_rlast", rlast_o, 1'b0);
      chk("E_rst_araddr", araddr_o, 64'd0);
      chk("E_rst_arlen", arlen_o, 8'd0);
      chk("E_rst_err", err_cnt_o, 8'd0);
      chk("E_rst_grant", grant_o, 1'b0);
      rvalid_i = 1'b0; s1_rready_i = 1'b0;
      @(posedge clk_a); #1;
      resetn_a = 1'b1;
      @(posedge clk_a); #1;
      s0_araddr_i = 64'h3000; s0_arlen_i = 8'd1;
      request(1'b1, 1'b0, won);
      chk("E_new_winner", won, 0);
      chk("E_new_araddr", araddr_o, 64'h3000);
      chk("E_new_arlen", arlen_o, 8'd1);
      addr_phase(1);
      data_phase(0, 2, 2, 0, 0, 2);
      chk("E_new_err", err_cnt_o, 8'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
